sad_best_match: RTL
===================

Name: sad_best_match

Overview:
- Sequencer and minimum-finder that sits downstream of the SAD datapath/controller pair, for block-matching motion estimation.
- Steps a candidate index through NUM_CAND candidate blocks. The index drives the B-memory block base. For each candidate it launches one SAD computation, consumes the resulting sad value, and keeps the smallest SAD and its index.
- Reports the best match with a done pulse. An error flag is raised if the SAD engine never answers.

Parameters:
- SAD_W, 32: width of sad input and best_sad output; matches the datapath sad register.
- IDX_W, 8: width of candidate index outputs. NUM_CAND <= 2**IDX_W is required.
- NUM_CAND, 16: number of candidate blocks per search; minimum 1.
- TIMEOUT, 1024: maximum cycles spent in WAIT per candidate before aborting. A 256-pixel SAD needs about 515 cycles.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a new search. Sampled only in IDLE.
- sad_done, input, 1: one-cycle pulse from the SAD controller; sad is valid in the same cycle.
- sad, input, SAD_W: SAD result for the current candidate.
- sad_go, output, 1: one-cycle launch pulse to the SAD controller.
- cand_idx, output, IDX_W: candidate currently being evaluated.
- best_sad, output, SAD_W: minimum SAD found so far or in the last search.
- best_idx, output, IDX_W: candidate index of best_sad.
- busy, output, 1: high from the cycle after start is accepted until DONE.
- done, output, 1: one-cycle pulse at the end of a search (normal or aborted).
- err, output, 1: timeout occurred in the last search. Held until the next accepted start.

Behaviour:
- All outputs are registered. Reset values:
  - state = IDLE
  - cand_idx = 0, best_sad = all ones, best_idx = 0
  - sad_go = 0, busy = 0, done = 0, err = 0
  - timeout counter = 0
- IDLE:
  - start=1 → next cycle: cand_idx=0, best_sad=all ones, best_idx=0, err=0, busy=1; go to LAUNCH.
  - start=0 → stay; best_sad, best_idx and err hold their last values.
- LAUNCH:
  - sad_go=1 for exactly one cycle, cand_idx stable; timeout counter cleared.
  - Go to WAIT.
- WAIT:
  - Timeout counter increments every cycle.
  - On sad_done=1, compare: if sad < best_sad (strict, unsigned), best_sad<=sad and best_idx<=cand_idx.
    - Ties keep the earlier (lower) index.
    - sad == all ones never updates, so best_idx stays 0 in that case.
  - After the compare:
    - cand_idx == NUM_CAND-1 → go to DONE.
    - otherwise cand_idx<=cand_idx+1 and go to LAUNCH.
  - If the counter reaches TIMEOUT-1 with no sad_done: err<=1 and go to DONE. best_sad/best_idx keep the partial result.
  - If sad_done arrives in the same cycle the counter hits the limit, sad_done wins and no error is raised.
- DONE:
  - done=1 for one cycle and busy<=0; return to IDLE.
  - cand_idx holds its final value.
- Latency per candidate: 1 (LAUNCH) + SAD engine latency + 1 (compare). There is no extra cycle between candidates beyond LAUNCH.
- Events ignored by state:
  - start while busy (LAUNCH/WAIT/DONE): ignored, no restart.
  - sad_done outside WAIT: ignored, no compare.
  - start and sad_done together in IDLE: start accepted, sad_done ignored.
- NUM_CAND=1: a single LAUNCH/WAIT, then DONE; cand_idx never increments.
- rst asserted mid-search: at the next edge all registers take their reset values. sad_go and busy drop immediately, and no done pulse is generated.
- sad_go is never high in two consecutive cycles.

Test Plan:
- Search with sad sequence 500, 300, 800, 120, then 200 for the rest (NUM_CAND=16) → done pulses once; best_sad=120, best_idx=3, err=0; sixteen sad_go pulses.
- Tie check with sad values 50, 40, 40, 40, then 90 for the rest → best_sad=40, best_idx=1 (earliest minimum kept).
- All 16 candidates return all-ones SAD → best_sad=32'hFFFFFFFF, best_idx=0, err=0, done pulses.
- SAD model stops answering at candidate 5, after candidates 0-4 returned 700, 650, 900, 600, 610 → after TIMEOUT cycles in WAIT: err=1, done pulses; best_sad=600, best_idx=3, cand_idx=5.
- start pulsed during WAIT of candidate 2, plus a stray sad_done during LAUNCH → no restart, no extra compare; the final result matches the clean run.
- rst asserted for 1 cycle while in WAIT of candidate 7 → next cycle all outputs are at reset values with no done pulse. A new start then runs a full 16-candidate search correctly.

Source files
------------

// File: rtl/sad_best_match.sv
// Steps through NUM_CAND candidate blocks, launches one SAD per candidate, and
// keeps the smallest SAD and its index. Reports the result with a done pulse.
// err is raised when the SAD engine does not answer within TIMEOUT cycles.
module sad_best_match #(
  parameter int SAD_W    = 32,
  parameter int IDX_W    = 8,
  parameter int NUM_CAND = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad,
  output logic             sad_go,
  output logic [IDX_W-1:0] cand_idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CAND - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             sad_go_q, sad_go_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and registered-output logic. sad_go and done are computed one
  // cycle ahead so that they are high exactly during LAUNCH and DONE.
  always_comb begin
    state_d    = state_q;
    cand_idx_d = cand_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    sad_go_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LAUNCH;
          cand_idx_d = '0;
          best_sad_d = '1;
          best_idx_d = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          sad_go_d   = 1'b1;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A result arriving on the limit cycle still counts: sad_done is
        // checked before the timeout.
        if (sad_done) begin
          if (sad < best_sad_q) begin
            best_sad_d = sad;
            best_idx_d = cand_idx_q;
          end
          if (cand_idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cand_idx_d = cand_idx_q + IDX_W'(1);
            state_d    = S_LAUNCH;
            sad_go_d   = 1'b1;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cand_idx_q <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
      sad_go_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cand_idx_q <= cand_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      sad_go_q   <= sad_go_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sad_go   = sad_go_q;
  assign cand_idx = cand_idx_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
